// File: rtl/shift_rotate_iter_if.sv
// Request/result bundle between the Ra/Rb/Z buses and the iterative shift/rotate unit.
interface shift_rotate_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] amount;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, a_in, amount,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a_in, amount,
    output busy, done, result
  );
endinterface

// File: rtl/shift_rotate_iter.sv
// Iterative shift/rotate: one bit per cycle, n cycles busy then a one-cycle done pulse.
// No backpressure; start is only accepted in IDLE and requests in RUN/DONE are dropped.
module shift_rotate_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clear,
  shift_rotate_iter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] res;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] amt_lo;
  logic             pass_thru;
  logic             unused_amount_hi;

  // Shift counts wrap modulo WIDTH: upper amount bits are deliberately dropped.
  assign amt_lo           = bus.amount[CNT_W-1:0];
  assign unused_amount_hi = ^bus.amount[WIDTH-1:CNT_W];
  assign pass_thru        = (bus.op > OP_ROL);

  function automatic logic [WIDTH-1:0] step(input logic [2:0] o, input logic [WIDTH-1:0] r);
    case (o)
      OP_SHR:  step = {1'b0, r[WIDTH-1:1]};
      OP_SHRA: step = {r[WIDTH-1], r[WIDTH-1:1]};
      OP_SHL:  step = {r[WIDTH-2:0], 1'b0};
      OP_ROR:  step = {r[0], r[WIDTH-1:1]};
      OP_ROL:  step = {r[WIDTH-2:0], r[WIDTH-1]};
      default: step = r;
    endcase
  endfunction

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (amt_lo == '0 || pass_thru) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      res  <= '0;
      op_q <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            res  <= bus.a_in;
            op_q <= bus.op;
            cnt  <= amt_lo;
          end
        end
        RUN: begin
          res <= step(op_q, res);
          cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.result = res;
endmodule

// File: tb/tb_shift_rotate_iter.sv
// Directed bench for shift_rotate_iter with a result/latency scoreboard.
module tb_shift_rotate_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic clear;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  logic [W-1:0] sb_res[$];
  int           sb_busy[$];

  shift_rotate_iter_if #(.WIDTH(W)) bus ();

  shift_rotate_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: apply n single-bit steps of the selected op.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] amt);
    logic [W-1:0] r;
    int           n;
    r = a;
    n = int'(amt % W);
    if (o > 3'd4) return a;
    for (int i = 0; i < n; i++) begin
      case (o)
        3'd0: r = r >> 1;
        3'd1: r = {r[W-1], r[W-1:1]};
        3'd2: r = r << 1;
        3'd3: r = {r[0], r[W-1:1]};
        default: r = {r[W-2:0], r[W-1]};
      endcase
    end
    return r;
  endfunction

  function automatic int exp_cycles(input logic [2:0] o, input logic [W-1:0] amt);
    return (o > 3'd4 || (amt % W) == 0) ? 0 : int'(amt % W);
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] amt);
    @(negedge clk);
    bus.op     = o;
    bus.a_in   = a;
    bus.amount = amt;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op     = 3'd2;
    bus.a_in   = ~a;
    bus.amount = amt + 7;
  endtask

  task automatic wait_done(output int nb, output bit ok);
    nb = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] amt, input logic [W-1:0] exp);
    int           nb;
    bit           ok;
    logic [W-1:0] e;
    int           eb;
    sb_res.push_back(exp);
    sb_busy.push_back(exp_cycles(o, amt));
    issue(o, a, amt);
    wait_done(nb, ok);
    e  = sb_res.pop_front();
    eb = sb_busy.pop_front();
    check({tag, " done seen"}, W'(ok), W'(1));
    check({tag, " busy cycles"}, W'(nb), W'(eb));
    check({tag, " result"}, bus.result, e);
    @(negedge clk);
    check({tag, " done width"}, W'(bus.done), W'(0));
    check({tag, " result held"}, bus.result, e);
  endtask

  initial begin
    int           nb;
    bit           ok;
    logic [W-1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [2:0]   ro;

    clear      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = '0;
    bus.a_in   = '0;
    bus.amount = '0;
    repeat (3) @(negedge clk);
    check("reset busy", W'(bus.busy), W'(0));
    check("reset done", W'(bus.done), W'(0));
    check("reset result", bus.result, W'(0));
    clear = 1'b0;
    @(negedge clk);
    check("idle busy", W'(bus.busy), W'(0));

    run_op("ror4", 3'd3, 32'h1234_5678, 32'd4, 32'h8123_4567);
    run_op("ror1", 3'd3, 32'h0000_0001, 32'd1, 32'h8000_0000);
    run_op("ror0", 3'd3, 32'h0000_0001, 32'd0, 32'h0000_0001);
    run_op("shra31", 3'd1, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    run_op("shr31", 3'd0, 32'h8000_0000, 32'd31, 32'h0000_0001);
    run_op("rol1", 3'd4, 32'h8000_0001, 32'd1, 32'h0000_0003);
    run_op("shl_wrap", 3'd2, 32'h0000_0001, 32'h0000_0025, 32'h0000_0020);
    run_op("ror32", 3'd3, 32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF);

    // Clear mid-operation must act without a clock edge.
    issue(3'd3, 32'h1234_5678, 32'd20);
    repeat (5) @(negedge clk);
    #2 clear = 1'b1;
    #1;
    check("clear busy", W'(bus.busy), W'(0));
    check("clear done", W'(bus.done), W'(0));
    check("clear result", bus.result, W'(0));
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    check("post clear idle", W'(bus.busy), W'(0));
    run_op("ror8", 3'd3, 32'h1234_5678, 32'd8, 32'h7812_3456);

    // Starts during RUN and DONE are dropped.
    sb_res.push_back(model(3'd3, 32'h1234_5678, 32'd10));
    sb_busy.push_back(10);
    issue(3'd3, 32'h1234_5678, 32'd10);
    nb = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) nb++;
      bus.start  = (i == 3);
      bus.op     = 3'd2;
      bus.a_in   = 32'h1;
      bus.amount = 32'd3;
      @(negedge clk);
    end
    bus.start = 1'b1;
    e = sb_res.pop_front();
    check("ign done seen", W'(ok), W'(1));
    check("ign busy cycles", W'(nb), W'(sb_busy.pop_front()));
    check("ign result", bus.result, e);
    @(negedge clk);
    bus.start = 1'b0;
    check("ign no restart busy", W'(bus.busy), W'(0));
    check("ign no restart done", W'(bus.done), W'(0));
    check("ign result held", bus.result, e);
    @(negedge clk);
    check("ign still idle", W'(bus.busy | bus.done), W'(0));

    run_op("pass111", 3'd7, 32'hCAFE_F00D, 32'd9, 32'hCAFE_F00D);

    for (int k = 0; k < 4; k++) begin
      ra = $urandom;
      rb = $urandom;
      ro = 3'($urandom_range(0, 5));
      run_op("rand", ro, ra, rb, model(ro, ra, rb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
